pll_reconfig_ctrl: RTL and testbench

- Sequences run-time reconfiguration of the 8-output system PLL through its Avalon-MM reconfiguration port, e.g. switching between a normal and a turbo clock profile.
- Accepts a profile index from the core and replays that profile's register-write list into the PLL reconfig block.
- Triggers the reconfiguration, then waits for the PLL to re-lock and reports done or error.
- Sits beside the PLL, running on the 50 MHz reference clock.

---
 rtl/pll_reconfig_pkg.sv | 48 ++++
 rtl/pll_reconfig_rom.sv | 30 +++
 rtl/pll_reconfig_ctrl.sv | 141 ++++++++++++++
 tb/tb_pll_reconfig_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_reconfig_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer: register map,
// FSM states and the per-profile register-write tables.
package pll_reconfig_pkg;

  localparam int MAX_WRITES     = 12;
  localparam int TABLE_PROFILES = 2;

  localparam logic [5:0] ADDR_MODE  = 6'h00;
  localparam logic [5:0] ADDR_START = 6'h02;
  localparam logic [5:0] ADDR_N     = 6'h03;
  localparam logic [5:0] ADDR_M     = 6'h04;
  localparam logic [5:0] ADDR_C     = 6'h05;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MODE,
    ST_LOAD,
    ST_START,
    ST_WAIT_DONE,
    ST_WAIT_LOCK,
    ST_DONE,
    ST_ERR
  } state_t;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } prof_entry_t;

  // C-counter data carries the counter select in [22:18], high/low counts below.
  localparam prof_entry_t PROFILE_ROM [TABLE_PROFILES][MAX_WRITES] = '{
    '{ '{ADDR_N, 32'h0000_0101}, '{ADDR_M, 32'h0000_0808},
       '{ADDR_C, 32'h0000_0404}, '{ADDR_C, 32'h0004_0808},
       '{ADDR_C, 32'h0008_0202}, '{ADDR_C, 32'h000C_0505},
       '{ADDR_C, 32'h0010_0A0A}, '{ADDR_C, 32'h0014_0303},
       '{ADDR_C, 32'h0018_0606}, '{ADDR_C, 32'h001C_0101},
       '{ADDR_MODE, 32'h0}, '{ADDR_MODE, 32'h0} },
    '{ '{ADDR_N, 32'h0000_0101}, '{ADDR_M, 32'h0000_0A0A},
       '{ADDR_C, 32'h0000_0303}, '{ADDR_C, 32'h0004_0606},
       '{ADDR_C, 32'h0008_0202}, '{ADDR_C, 32'h000C_0404},
       '{ADDR_C, 32'h0010_0808}, '{ADDR_C, 32'h0014_0202},
       '{ADDR_C, 32'h0018_0505}, '{ADDR_C, 32'h001C_0101},
       '{ADDR_MODE, 32'h0}, '{ADDR_MODE, 32'h0} }
  };

  localparam logic [3:0] PROFILE_LEN [TABLE_PROFILES] = '{4'd10, 4'd10};

endpackage

// File: rtl/pll_reconfig_rom.sv
// Combinational profile-table lookup: (sel, idx) -> register write, plus the
// profile's write count. Profiles without a table entry report length 0.
module pll_reconfig_rom
  import pll_reconfig_pkg::*;
(
  input  logic [2:0]  sel,
  input  logic [3:0]  idx,
  output logic [5:0]  addr,
  output logic [31:0] data,
  output logic [3:0]  len
);

  always_comb begin
    addr = '0;
    data = '0;
    len  = '0;
    for (int p = 0; p < TABLE_PROFILES; p++) begin
      if (sel == 3'(p)) begin
        len = PROFILE_LEN[p];
        for (int w = 0; w < MAX_WRITES; w++) begin
          if (idx == 4'(w)) begin
            addr = PROFILE_ROM[p][w].addr;
            data = PROFILE_ROM[p][w].data;
          end
        end
      end
    end
  end

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// Replays a selected clock profile into the PLL reconfig port over Avalon-MM,
// triggers reconfiguration and waits for a stable re-lock (done) or timeout (err).
module pll_reconfig_ctrl
  import pll_reconfig_pkg::*;
#(
  parameter int NUM_PROFILES = 2,
  parameter int LOCK_STABLE  = 64,
  parameter int LOCK_TIMEOUT = 1_000_000
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        cfg_req,
  input  logic [2:0]  cfg_sel,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  cur_sel,
  input  logic        pll_locked,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  input  logic        mgmt_waitrequest
);

  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam logic [TW:0] TO_LAST = (TW + 1)'(LOCK_TIMEOUT);
  localparam logic [SW:0] ST_LAST = (SW + 1)'(LOCK_STABLE);
  localparam logic [3:0]  NPROF   = 4'(NUM_PROFILES);

  state_t        state, state_nx;
  logic [2:0]    sel_q, cur_sel_q, pend_sel, req_sel;
  logic [3:0]    idx, rom_len;
  logic [5:0]    rom_addr;
  logic [31:0]   rom_data;
  logic          pend_v, rej_q, lock_m, lock_s;
  logic          req_v, sel_ok, accept, tcnt_hit;
  logic [TW-1:0] tcnt;
  logic [TW:0]   tcnt_inc;
  logic [SW-1:0] scnt;
  logic [SW:0]   scnt_inc;

  pll_reconfig_rom u_rom (
    .sel  (sel_q),
    .idx  (idx),
    .addr (rom_addr),
    .data (rom_data),
    .len  (rom_len)
  );

  // A held pending request takes priority over a fresh cfg_req in IDLE.
  assign req_v    = pend_v | cfg_req;
  assign req_sel  = pend_v ? pend_sel : cfg_sel;
  assign sel_ok   = {1'b0, req_sel} < NPROF;
  assign accept   = mgmt_write & ~mgmt_waitrequest;
  assign tcnt_inc = {1'b0, tcnt} + (TW + 1)'(1);
  assign scnt_inc = {1'b0, scnt} + (SW + 1)'(1);
  assign tcnt_hit = (tcnt_inc == TO_LAST);

  always_comb begin
    state_nx       = state;
    mgmt_write     = 1'b0;
    mgmt_address   = '0;
    mgmt_writedata = '0;
    case (state)
      ST_IDLE: if (req_v && sel_ok) state_nx = ST_MODE;
      ST_MODE: begin
        mgmt_write   = 1'b1;
        mgmt_address = ADDR_MODE;
        if (accept) state_nx = (rom_len == 4'd0) ? ST_START : ST_LOAD;
      end
      ST_LOAD: begin
        mgmt_write     = 1'b1;
        mgmt_address   = rom_addr;
        mgmt_writedata = rom_data;
        if (accept && idx == rom_len - 4'd1) state_nx = ST_START;
      end
      ST_START: begin
        mgmt_write     = 1'b1;
        mgmt_address   = ADDR_START;
        mgmt_writedata = 32'd1;
        if (accept) state_nx = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (tcnt_hit) state_nx = ST_ERR;
        else if (!mgmt_waitrequest) state_nx = ST_WAIT_LOCK;
      end
      // Stable lock is checked first so it wins a same-cycle tie with timeout.
      ST_WAIT_LOCK: begin
        if (lock_s && scnt_inc == ST_LAST) state_nx = ST_DONE;
        else if (tcnt_hit) state_nx = ST_ERR;
      end
      ST_DONE: state_nx = ST_IDLE;
      ST_ERR:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= ST_IDLE;
      sel_q     <= '0;
      cur_sel_q <= '0;
      pend_v    <= 1'b0;
      pend_sel  <= '0;
      rej_q     <= 1'b0;
      idx       <= '0;
      tcnt      <= '0;
      scnt      <= '0;
      lock_m    <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      state  <= state_nx;
      lock_m <= pll_locked;
      lock_s <= lock_m;
      rej_q  <= (state == ST_IDLE) && req_v && !sel_ok;
      if (state == ST_IDLE && req_v) sel_q <= req_sel;
      if (state == ST_MODE) idx <= '0;
      else if (state == ST_LOAD && accept) idx <= idx + 4'd1;
      if (state == ST_WAIT_DONE || state == ST_WAIT_LOCK) tcnt <= tcnt_inc[TW-1:0];
      else tcnt <= '0;
      if (state == ST_WAIT_LOCK && lock_s) scnt <= scnt_inc[SW-1:0];
      else scnt <= '0;
      // cur_sel changes with the done pulse so both are coherent in one cycle.
      if (state == ST_WAIT_LOCK && state_nx == ST_DONE) cur_sel_q <= sel_q;
      if (cfg_req && !(state == ST_IDLE && !pend_v)) begin
        pend_v   <= 1'b1;
        pend_sel <= cfg_sel;
      end else if (state == ST_IDLE && pend_v) begin
        pend_v <= 1'b0;
      end
    end
  end

  assign busy    = (state == ST_MODE) || (state == ST_LOAD) || (state == ST_START) ||
                   (state == ST_WAIT_DONE) || (state == ST_WAIT_LOCK);
  assign done    = (state == ST_DONE);
  assign err     = (state == ST_ERR) || rej_q;
  assign cur_sel = cur_sel_q;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl: expected Avalon writes and done/err
// events are queued by the stimulus and checked by a negedge monitor.
module tb_pll_reconfig_ctrl;

  localparam int LOCK_STABLE  = 64;
  localparam int LOCK_TIMEOUT = 1000;

  logic        refclk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_req = 1'b0;
  logic [2:0]  cfg_sel = 3'd0;
  logic        busy, done, err;
  logic [2:0]  cur_sel;
  logic        pll_locked = 1'b0;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest = 1'b0;

  pll_reconfig_ctrl #(
    .NUM_PROFILES (2),
    .LOCK_STABLE  (LOCK_STABLE),
    .LOCK_TIMEOUT (LOCK_TIMEOUT)
  ) dut (
    .refclk           (refclk),
    .rst              (rst),
    .cfg_req          (cfg_req),
    .cfg_sel          (cfg_sel),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .cur_sel          (cur_sel),
    .pll_locked       (pll_locked),
    .mgmt_address     (mgmt_address),
    .mgmt_write       (mgmt_write),
    .mgmt_writedata   (mgmt_writedata),
    .mgmt_waitrequest (mgmt_waitrequest)
  );

  // ---------------- clock / cycle count ----------------
  always #10 refclk = ~refclk;

  int cyc = 0;
  always @(posedge refclk) cyc = cyc + 1;

  // ---------------- scoreboard state ----------------
  int  total = 0, bad = 0;
  int  ea_cyc = 0, req_cyc = 0, ref_cyc = 0;
  int  slave_wait = 0, lock_mode = 0, wcnt = 0, hold = 0;
  bit  started = 1'b0, new_write = 1'b1;
  logic [5:0]  h_addr;
  logic [31:0] h_data;
  logic [41:0] wr_act, wr_exp;
  logic [31:0] ev_act, ev_exp;
  logic [41:0] wr_q[$];  // {hold cycles[3:0], addr[5:0], data[31:0]}
  logic [31:0] ev_q[$];  // {done, err, busy, cur_sel[2:0], delay[25:0]}

  logic [37:0] prof [2][10] = '{
    '{ {6'h03, 32'h0000_0101}, {6'h04, 32'h0000_0808}, {6'h05, 32'h0000_0404},
       {6'h05, 32'h0004_0808}, {6'h05, 32'h0008_0202}, {6'h05, 32'h000C_0505},
       {6'h05, 32'h0010_0A0A}, {6'h05, 32'h0014_0303}, {6'h05, 32'h0018_0606},
       {6'h05, 32'h001C_0101} },
    '{ {6'h03, 32'h0000_0101}, {6'h04, 32'h0000_0A0A}, {6'h05, 32'h0000_0303},
       {6'h05, 32'h0004_0606}, {6'h05, 32'h0008_0202}, {6'h05, 32'h000C_0404},
       {6'h05, 32'h0010_0808}, {6'h05, 32'h0014_0202}, {6'h05, 32'h0018_0505},
       {6'h05, 32'h001C_0101} }
  };

  // ---------------- Avalon slave model ----------------
  // Holds waitrequest for slave_wait cycles at the start of every write.
  always @(posedge refclk) begin
    #1;
    if (mgmt_write) begin
      if (new_write) wcnt = slave_wait;
      mgmt_waitrequest = (wcnt != 0);
      if (wcnt != 0) wcnt = wcnt - 1;
      new_write = !mgmt_waitrequest;
    end else begin
      mgmt_waitrequest = 1'b0;
      new_write = 1'b1;
    end
  end

  // ---------------- PLL lock model (t = cycles since START accept) ----------------
  always @(posedge refclk) begin
    int t;
    #2;
    t = cyc - ea_cyc;
    case (lock_mode)
      1:       pll_locked = 1'b1;
      2:       pll_locked = started && (t >= 3);
      3:       pll_locked = started && (t >= 3) && (t != 43);
      default: pll_locked = 1'b0;
    endcase
  end

  // ---------------- monitor ----------------
  always @(negedge refclk) begin
    if (mgmt_write) begin
      if (hold == 0) begin
        h_addr = mgmt_address;
        h_data = mgmt_writedata;
      end else begin
        total++;
        if (mgmt_address !== h_addr || mgmt_writedata !== h_data) begin
          bad++;
          $display("FAIL write_stable got %h/%h want %h/%h", mgmt_address, mgmt_writedata, h_addr, h_data);
        end
      end
      hold++;
      if (!mgmt_waitrequest) begin
        wr_act = {4'(hold), mgmt_address, mgmt_writedata};
        total++;
        if (wr_q.size() == 0) begin
          bad++;
          $display("FAIL write_unexpected got %h want none", wr_act);
        end else begin
          wr_exp = wr_q.pop_front();
          if (wr_act !== wr_exp) begin
            bad++;
            $display("FAIL write got %h want %h", wr_act, wr_exp);
          end
        end
        if (mgmt_address == 6'h02) begin
          started = 1'b1;
          ea_cyc  = cyc + 1;
        end
        hold = 0;
      end
    end else begin
      hold = 0;
    end
    if (done || err) begin
      ref_cyc = started ? ea_cyc : req_cyc;
      ev_act  = {done, err, busy, cur_sel, 26'(cyc - ref_cyc)};
      total++;
      if (ev_q.size() == 0) begin
        bad++;
        $display("FAIL event_unexpected got %h want none", ev_act);
      end else begin
        ev_exp = ev_q.pop_front();
        if (ev_act !== ev_exp) begin
          bad++;
          $display("FAIL event got %h want %h", ev_act, ev_exp);
        end
      end
      started = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_job(input logic [2:0] sel, input int hold_cycles);
    logic [3:0] h;
    h = 4'(hold_cycles);
    wr_q.push_back({h, 6'h00, 32'h0});
    for (int i = 0; i < 10; i++) wr_q.push_back({h, prof[sel[0]][i]});
    wr_q.push_back({h, 6'h02, 32'h1});
  endtask

  task automatic push_ev(input logic [1:0] kind, input logic [2:0] csel, input int delay);
    ev_q.push_back({kind, 1'b0, csel, 26'(delay)});
  endtask

  task automatic issue_req(input int sel);
    @(posedge refclk);
    #1;
    cfg_req = 1'b1;
    cfg_sel = 3'(sel);
    @(posedge refclk);
    #1;
    req_cyc = cyc;
    cfg_req = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((wr_q.size() != 0 || ev_q.size() != 0) && n < budget) begin
      @(posedge refclk);
      n++;
    end
    total++;
    if (wr_q.size() != 0 || ev_q.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout got writes_left=%0d events_left=%0d want 0/0", name, wr_q.size(), ev_q.size());
      wr_q.delete();
      ev_q.delete();
    end
    repeat (4) @(posedge refclk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    repeat (3) @(posedge refclk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_cur_sel", 32'(cur_sel), 0);
    check("rst_write", 32'(mgmt_write), 0);
    check("rst_addr", 32'(mgmt_address), 0);
    check("rst_data", mgmt_writedata, 0);
    rst = 1'b0;

    // Out-of-range profile: err next cycle, no bus writes.
    push_ev(2'b01, 3'd0, 0);
    issue_req(5);
    wait_idle("reject", 50);

    // Lock never comes: err 1000 cycles after START accept.
    lock_mode = 0;
    push_job(3'd1, 1);
    push_ev(2'b01, 3'd0, LOCK_TIMEOUT);
    issue_req(1);
    wait_idle("timeout", 3000);

    // Nominal: lock_s high 5 cycles after START accept.
    lock_mode = 2;
    push_job(3'd1, 1);
    push_ev(2'b10, 3'd1, LOCK_STABLE + 5);
    issue_req(1);
    wait_idle("nominal", 500);

    // Slow slave: each write held 4 cycles.
    slave_wait = 3;
    push_job(3'd0, 4);
    push_ev(2'b10, 3'd0, LOCK_STABLE + 5);
    issue_req(0);
    wait_idle("waitreq", 500);
    slave_wait = 0;

    // Lock glitch restarts the stability count.
    lock_mode = 3;
    push_job(3'd1, 1);
    push_ev(2'b10, 3'd1, 46 + LOCK_STABLE);
    issue_req(1);
    wait_idle("glitch", 500);

    // Two requests while busy: only the last (sel=0) runs afterwards.
    lock_mode = 1;
    push_job(3'd1, 1);
    push_ev(2'b10, 3'd1, LOCK_STABLE + 1);
    push_job(3'd0, 1);
    push_ev(2'b10, 3'd0, LOCK_STABLE + 1);
    issue_req(1);
    repeat (3) @(posedge refclk);
    issue_req(1);
    issue_req(0);
    wait_idle("pending", 1000);
    check("pending_cur_sel", 32'(cur_sel), 0);

    // Reset in the middle of the table load.
    push_job(3'd1, 1);
    push_ev(2'b10, 3'd1, LOCK_STABLE + 1);
    issue_req(1);
    wait_idle("pre_reset", 500);
    check("pre_reset_cur_sel", 32'(cur_sel), 1);
    push_job(3'd1, 1);
    issue_req(1);
    repeat (3) @(posedge refclk);
    #1;
    rst = 1'b1;
    @(posedge refclk);
    #1;
    check("midrst_write", 32'(mgmt_write), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_cur_sel", 32'(cur_sel), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_err", 32'(err), 0);
    rst = 1'b0;
    wr_q.delete();
    started = 1'b0;
    repeat (100) @(posedge refclk);
    check("final_events_left", 32'(ev_q.size()), 0);
    check("final_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
